// File: rtl/datapath_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | datapath_pkg : shared widths and sizing helpers for the datapath registers |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package datapath_pkg;

   localparam int WORD_W = 32;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // A single-entry buffer still needs a one-bit pointer.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? clog2(depth) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wrap_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wrap_ptr : circular pointer with increment enable, sync clear and wrap     |
// |            at DEPTH-1; updates on the falling clock edge                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module wrap_ptr #(
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = '0;
      end else if (inc) begin
         ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
      end
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/elastic_data_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | elastic_data_reg : DEPTH-entry valid/ready holding register for datapath   |
// |                    stages; ELASTIC_BYPASS_EN enables zero-latency bypass   |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module elastic_data_reg
   import datapath_pkg::*;
#(
   parameter  int WIDTH = WORD_W,
   parameter  int DEPTH = 2,
   localparam int PTR_W = ptr_width(DEPTH),
   localparam int CNT_W = clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             FLUSH,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] DataIn,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] DataOut,
   output logic [CNT_W-1:0] Count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             in_ready_q;
   logic             in_ready_d;
   logic             out_valid_q;
   logic             out_valid_d;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             bypass;
   logic             push;
   logic             pop;

`ifdef ELASTIC_BYPASS_EN
   assign bypass = (count_q == '0) && InValid;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed word that is taken immediately never enters storage.
   assign push = InValid && in_ready_q && !(bypass && OutReady) && !FLUSH;
   assign pop  = out_valid_q && OutReady && !FLUSH;

   always_comb begin
      count_d = count_q;
      if (FLUSH) begin
         count_d = '0;
      end else if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
      in_ready_d  = (count_d != CNT_W'(DEPTH));
      out_valid_d = (count_d != '0);
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (push && (wr_ptr == PTR_W'(i))) begin
            mem_d[i] = DataIn;
         end
      end
   end

   always_ff @(negedge CLK) begin
      if (RST) begin
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   wrap_ptr #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_wr_ptr (
      .clk (CLK),
      .rst (RST),
      .clr (FLUSH),
      .inc (push),
      .ptr (wr_ptr)
   );

   wrap_ptr #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_rd_ptr (
      .clk (CLK),
      .rst (RST),
      .clr (FLUSH),
      .inc (pop),
      .ptr (rd_ptr)
   );

   assign InReady = in_ready_q;
   assign Count   = count_q;

`ifdef ELASTIC_BYPASS_EN
   assign OutValid = out_valid_q || bypass;
   assign DataOut  = bypass ? DataIn : mem_q[rd_ptr];
`else
   assign OutValid = out_valid_q;
   assign DataOut  = mem_q[rd_ptr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_elastic_data_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_elastic_data_reg : bench for elastic_data_reg at DEPTH=2 and DEPTH=3,   |
// |                       queue reference model; honours ELASTIC_BYPASS_EN     |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
module tb_elastic_data_reg;

`ifdef ELASTIC_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] data_in;
   logic        in_ready2, out_valid2, in_ready3, out_valid3;
   logic [31:0] data_out2, data_out3;
   logic [1:0]  count2, count3;

   int total = 0;
   int bad   = 0;

   logic [31:0] m2 [$];
   logic [31:0] m3 [$];

   always #5 clk = ~clk;

   elastic_data_reg #(.WIDTH(32), .DEPTH(2)) dut2 (
      .CLK(clk), .RST(rst), .FLUSH(flush), .InValid(in_valid), .InReady(in_ready2),
      .DataIn(data_in), .OutValid(out_valid2), .OutReady(out_ready),
      .DataOut(data_out2), .Count(count2)
   );

   elastic_data_reg #(.WIDTH(32), .DEPTH(3)) dut3 (
      .CLK(clk), .RST(rst), .FLUSH(flush), .InValid(in_valid), .InReady(in_ready3),
      .DataIn(data_in), .OutValid(out_valid3), .OutReady(out_ready),
      .DataOut(data_out3), .Count(count3)
   );

   // -1 clear, otherwise bit1 = push, bit0 = pop
   function automatic int model_act(input int size, input int depth);
      int a;
      if (rst || flush) return -1;
      if (BYP && size == 0 && in_valid && out_ready) return 0;
      a = 0;
      if (in_valid && size < depth) a |= 2;
      if (size > 0 && out_ready)    a |= 1;
      return a;
   endfunction

   task automatic model_edge();
      int a2, a3;
      a2 = model_act(m2.size(), 2);
      a3 = model_act(m3.size(), 3);
      if (a2 < 0) m2.delete();
      else begin
         if (a2[0]) void'(m2.pop_front());
         if (a2[1]) m2.push_back(data_in);
      end
      if (a3 < 0) m3.delete();
      else begin
         if (a3[0]) void'(m3.pop_front());
         if (a3[1]) m3.push_back(data_in);
      end
   endtask

   task automatic tick();
      model_edge();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
      @(posedge clk); #1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      total++;
      if ({count2, out_valid2, in_ready2} !== 4'b0001) begin
         bad++; $display("FAIL reset_ctrl2 got=%b want=0001", {count2, out_valid2, in_ready2});
      end
      total++;
      if (data_out2 !== 32'h0) begin
         bad++; $display("FAIL reset_data2 got=%h want=00000000", data_out2);
      end
      total++;
      if ({count3, out_valid3, in_ready3, data_out3} !== {4'b0001, 32'h0}) begin
         bad++; $display("FAIL reset_dut3 got=%b/%h want=0001/0", {count3, out_valid3, in_ready3}, data_out3);
      end
   endtask

   task automatic test_fill();
      out_ready = 1'b0; in_valid = 1'b1;
      data_in = 32'hA5A5A5A5; tick();
      data_in = 32'h5A5A5A5A; tick();
      #1;
      total++;
      if ({count2, in_ready2, out_valid2, data_out2} !== {2'd2, 1'b0, 1'b1, 32'hA5A5A5A5}) begin
         bad++; $display("FAIL fill_full got=%0d/%b/%b/%h want=2/0/1/a5a5a5a5", count2, in_ready2, out_valid2, data_out2);
      end
      data_in = 32'hDEADBEEF; tick();
      #1;
      total++;
      if ({count2, data_out2} !== {2'd2, 32'hA5A5A5A5}) begin
         bad++; $display("FAIL fill_third_ignored got=%0d/%h want=2/a5a5a5a5", count2, data_out2);
      end
      total++;
      if ({count3, in_ready3} !== {2'd3, 1'b0}) begin
         bad++; $display("FAIL fill_dut3 got=%0d/%b want=3/0", count3, in_ready3);
      end
   endtask

   task automatic test_full_pop();
      in_valid = 1'b1; out_ready = 1'b1; data_in = 32'h11111111;
      tick();
      in_valid = 1'b0;
      #1;
      total++;
      if ({count2, in_ready2, out_valid2, data_out2} !== {2'd1, 1'b1, 1'b1, 32'h5A5A5A5A}) begin
         bad++; $display("FAIL full_pop got=%0d/%b/%b/%h want=1/1/1/5a5a5a5a", count2, in_ready2, out_valid2, data_out2);
      end
      total++;
      if ({count3, data_out3} !== {2'd2, 32'h5A5A5A5A}) begin
         bad++; $display("FAIL full_pop3 got=%0d/%h want=2/5a5a5a5a", count3, data_out3);
      end
      tick();
      tick();
      total++;
      if ({count2, count3} !== 4'd0) begin
         bad++; $display("FAIL drain got=%0d,%0d want=0,0", count2, count3);
      end
   endtask

   task automatic test_stream();
      int sent = 0;
      int rcv  = 0;
      int cyc  = 0;
      while (rcv < 7 && cyc < 200) begin
         in_valid  = (sent < 7);
         data_in   = 32'(sent + 1);
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (in_valid && in_ready3) sent++;
         if (out_valid3 && out_ready) begin
            total++;
            if (data_out3 !== 32'(rcv + 1)) begin
               bad++; $display("FAIL stream_order got=%0d want=%0d", data_out3, rcv + 1);
            end
            rcv++;
         end
         tick();
         cyc++;
      end
      total++;
      if (rcv != 7) begin
         bad++; $display("FAIL stream_timeout got=%0d words want=7", rcv);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick(); tick();
      total++;
      if ({count2, count3, out_valid3} !== 5'd0) begin
         bad++; $display("FAIL stream_empty got=%0d,%0d,%b want=0,0,0", count2, count3, out_valid3);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1;
      data_in = 32'hC0DE0001; tick();
      data_in = 32'hC0DE0002; tick();
      flush = 1'b1; data_in = 32'h00000BAD;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      total++;
      if ({count2, out_valid2, in_ready2, count3} !== {2'd0, 1'b0, 1'b1, 2'd0}) begin
         bad++; $display("FAIL flush got=%0d/%b/%b/%0d want=0/0/1/0", count2, out_valid2, in_ready2, count3);
      end
      tick();
      total++;
      if ({count2, out_valid2} !== 3'd0) begin
         bad++; $display("FAIL flush_drop got=%0d/%b want=0/0", count2, out_valid2);
      end
      in_valid = 1'b1;
      data_in = 32'hC0DE0003; tick();
      data_in = 32'hC0DE0004; tick();
      rst = 1'b1; flush = 1'b1; data_in = 32'hC0DE0005;
      tick();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      #1;
      total++;
      if ({count2, out_valid2, in_ready2, data_out2} !== {2'd0, 1'b0, 1'b1, 32'h0}) begin
         bad++; $display("FAIL rst_flush got=%0d/%b/%b/%h want=0/0/1/0", count2, out_valid2, in_ready2, data_out2);
      end
   endtask

   task automatic test_bypass();
      in_valid = 1'b1; out_ready = 1'b1; data_in = 32'h12345678;
      #1;
      total++;
      if (BYP) begin
         if ({out_valid2, data_out2} !== {1'b1, 32'h12345678}) begin
            bad++; $display("FAIL bypass_same got=%b/%h want=1/12345678", out_valid2, data_out2);
         end
      end else if (out_valid2 !== 1'b0) begin
         bad++; $display("FAIL bypass_none got=%b want=0", out_valid2);
      end
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      total++;
      if (BYP) begin
         if ({count2, out_valid2} !== 3'd0) begin
            bad++; $display("FAIL bypass_count got=%0d/%b want=0/0", count2, out_valid2);
         end
      end else if ({count2, out_valid2, data_out2} !== {2'd1, 1'b1, 32'h12345678}) begin
         bad++; $display("FAIL bypass_next got=%0d/%b/%h want=1/1/12345678", count2, out_valid2, data_out2);
      end
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_random();
      logic        ev;
      logic [31:0] ed;
      for (int c = 0; c < 300; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         flush     = ($urandom_range(0, 15) == 0);
         data_in   = $urandom();
         #1;
         ev = (m2.size() > 0) || (BYP && in_valid);
         ed = (m2.size() > 0) ? m2[0] : data_in;
         total++;
         if ({count2, in_ready2, out_valid2} !== {2'(m2.size()), m2.size() < 2, ev} ||
             (ev && data_out2 !== ed)) begin
            bad++; $display("FAIL rand2 cyc=%0d got=%0d/%b/%b/%h want=%0d/%b/%b/%h", c,
                            count2, in_ready2, out_valid2, data_out2, m2.size(), m2.size() < 2, ev, ed);
         end
         ev = (m3.size() > 0) || (BYP && in_valid);
         ed = (m3.size() > 0) ? m3[0] : data_in;
         total++;
         if ({count3, in_ready3, out_valid3} !== {2'(m3.size()), m3.size() < 3, ev} ||
             (ev && data_out3 !== ed)) begin
            bad++; $display("FAIL rand3 cyc=%0d got=%0d/%b/%b/%h want=%0d/%b/%b/%h", c,
                            count3, in_ready3, out_valid3, data_out3, m3.size(), m3.size() < 3, ev, ed);
         end
         tick();
      end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_pop();
      test_stream();
      test_flush();
      test_bypass();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
